// File: rtl/key_pacer_pkg.sv
// Shared types and helpers for the key event pacer.
package key_pacer_pkg;

    // Replay state machine: present a key, then hold a quiet gap.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } pacer_state_e;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with synchronous active-low reset.
// dout always shows the oldest entry, so a pop consumes the value seen this cycle.
module sync_fifo
    import key_pacer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [WIDTH-1:0]                din,
    input  logic                            pop,
    output logic [WIDTH-1:0]                dout,
    output logic [count_width(DEPTH)-1:0]   count,
    output logic                            full,
    output logic                            empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    // A push while full is still accepted when a pop frees a slot in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/key_event_pacer.sv
// Captures front-panel key presses, buffers them, and replays each one to the
// calculator as a valid pulse timed on a slow tick, so no press is lost or repeated.
module key_event_pacer
    import key_pacer_pkg::*;
#(
    parameter int KEY_W       = 4,
    parameter int DIV         = 16,
    parameter int DEPTH       = 8,
    parameter int HOLD_TICKS  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [KEY_W-1:0]                key_in,
    input  logic                            key_valid_in,
    input  logic                            clr_ovf,
    output logic                            tick,
    output logic                            slow_clk,
    output logic [KEY_W-1:0]                key_out,
    output logic                            key_valid_out,
    output logic [count_width(DEPTH)-1:0]   fifo_count,
    output logic                            overflow
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HC_W  = $clog2(HOLD_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_TICKS);

    logic [KEY_W:0]     sync_bus_s;
    logic [KEY_W-1:0]   sync_key_s;
    logic               sync_valid_s;
    logic               valid_prev_r;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;

    logic [DIV_W-1:0]   div_cnt_r;
    logic               tick_r;
    logic               slow_clk_r;

    logic [KEY_W-1:0]   fifo_dout_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    pacer_state_e       state_r;
    pacer_state_e       state_nx_s;
    logic [HC_W-1:0]    hc_r;
    logic [HC_W-1:0]    hc_nx_s;
    logic [HC_W-1:0]    hc_inc_s;
    logic [KEY_W-1:0]   key_r;
    logic [KEY_W-1:0]   key_nx_s;
    logic               valid_r;
    logic               valid_nx_s;
    logic               overflow_r;

    // Key code and valid travel together through the same synchroniser chain.
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [KEY_W:0] stage_r [SYNC_STAGES];

            // Multi-flop synchroniser for the UART-domain key bus.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage_r[i] <= '0;
                    end
                end else begin
                    stage_r[0] <= {key_valid_in, key_in};
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign sync_bus_s = stage_r[SYNC_STAGES-1];
        end else begin : g_bypass
            assign sync_bus_s = {key_valid_in, key_in};
        end
    endgenerate

    assign sync_key_s   = sync_bus_s[KEY_W-1:0];
    assign sync_valid_s = sync_bus_s[KEY_W];

    // Only a rising edge of valid counts as a press; holding the key does not repeat.
    assign push_s = sync_valid_s & ~valid_prev_r;
    assign drop_s = push_s & fifo_full_s & ~pop_s;

    // Previous synchronised valid for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_prev_r <= 1'b0;
        end else begin
            valid_prev_r <= sync_valid_s;
        end
    end

    // Free-running divider: tick and slow_clk change in the cycle after the wrap count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r  <= '0;
            tick_r     <= 1'b0;
            slow_clk_r <= 1'b0;
        end else begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r  <= '0;
                tick_r     <= 1'b1;
                slow_clk_r <= ~slow_clk_r;
            end else begin
                div_cnt_r  <= div_cnt_r + DIV_W'(1);
                tick_r     <= 1'b0;
                slow_clk_r <= slow_clk_r;
            end
        end
    end

    sync_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (sync_key_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .count (fifo_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sticky drop flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign hc_inc_s = hc_r + HC_W'(1);

    // Replay FSM next state: pop on an idle tick, hold valid, then hold a gap.
    always_comb begin
        state_nx_s = state_r;
        hc_nx_s    = hc_r;
        key_nx_s   = key_r;
        valid_nx_s = valid_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_r && !fifo_empty_s) begin
                    pop_s      = 1'b1;
                    key_nx_s   = fifo_dout_s;
                    valid_nx_s = 1'b1;
                    hc_nx_s    = '0;
                    state_nx_s = ASSERT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ASSERT: begin
                if (tick_r) begin
                    if (hc_inc_s == HOLD_LAST) begin
                        valid_nx_s = 1'b0;
                        hc_nx_s    = '0;
                        state_nx_s = GAP;
                    end else begin
                        hc_nx_s = hc_inc_s;
                    end
                end else begin
                    hc_nx_s = hc_r;
                end
            end
            GAP: begin
                if (tick_r) begin
                    if (hc_inc_s == HOLD_LAST) begin
                        hc_nx_s    = '0;
                        state_nx_s = IDLE;
                    end else begin
                        hc_nx_s = hc_inc_s;
                    end
                end else begin
                    hc_nx_s = hc_r;
                end
            end
            default: begin
                valid_nx_s = 1'b0;
                hc_nx_s    = '0;
                state_nx_s = IDLE;
            end
        endcase
    end

    // Replay FSM registers, including the registered calculator outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            hc_r    <= '0;
            key_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            hc_r    <= hc_nx_s;
            key_r   <= key_nx_s;
            valid_r <= valid_nx_s;
        end
    end

    assign tick          = tick_r;
    assign slow_clk      = slow_clk_r;
    assign key_out       = key_r;
    assign key_valid_out = valid_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_key_event_pacer.sv
// Directed bench for key_event_pacer with DIV=4, DEPTH=4, HOLD_TICKS=2, SYNC_STAGES=2.
// Cycle numbers count rising edges after reset release; samples are taken 1 time unit after each edge.
module tb_key_event_pacer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'd0;
    logic       key_valid_in = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       tick;
    logic       slow_clk;
    logic [3:0] key_out;
    logic       key_valid_out;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    key_event_pacer #(
        .KEY_W       (4),
        .DIV         (4),
        .DEPTH       (4),
        .HOLD_TICKS  (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_valid_in  (key_valid_in),
        .clr_ovf       (clr_ovf),
        .tick          (tick),
        .slow_clk      (slow_clk),
        .key_out       (key_out),
        .key_valid_out (key_valid_out),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s @cyc %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tick", tick, 1'b0);
        check("rst_slow", slow_clk, 1'b0);
        check("rst_key", key_out, 4'd0);
        check("rst_kvo", key_valid_out, 1'b0);
        check("rst_cnt", fifo_count, 3'd0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        cyc = 0;

        // Divider: tick every 4th clk starting 4 clk after release, slow_clk period 8
        for (int i = 1; i <= 40; i++) begin
            step_to(i);
            check("div_tick", tick, (i % 4 == 0) ? 1'b1 : 1'b0);
            check("div_slow", slow_clk, ((i / 4) % 2 == 1) ? 1'b1 : 1'b0);
            check("div_idle_kvo", key_valid_out, 1'b0);
            check("div_idle_cnt", fifo_count, 3'd0);
        end
        check("div_key", key_out, 4'd0);
        check("div_ovf", overflow, 1'b0);

        // Single press: key 5 held for 30 clk
        key_in = 4'd5;
        key_valid_in = 1'b1;
        step_to(42);
        check("single_cnt_pre", fifo_count, 3'd0);
        step_to(43);
        check("single_cnt_push", fifo_count, 3'd1);
        step_to(44);
        check("single_kvo_wait", key_valid_out, 1'b0);
        for (int i = 45; i <= 52; i++) begin
            step_to(i);
            check("single_kvo_hi", key_valid_out, 1'b1);
            check("single_key", key_out, 4'd5);
            check("single_cnt_pop", fifo_count, 3'd0);
        end
        for (int i = 53; i <= 70; i++) begin
            step_to(i);
            check("single_kvo_lo", key_valid_out, 1'b0);
            check("single_no_repush", fifo_count, 3'd0);
        end
        check("single_key_keep", key_out, 4'd5);
        key_valid_in = 1'b0;

        // Burst: keys 3, 7, 9
        step_to(76);  key_in = 4'd3; key_valid_in = 1'b1;
        step_to(78);  key_valid_in = 1'b0;
        step_to(80);  check("burst_kvo80", key_valid_out, 1'b0);
        key_in = 4'd7; key_valid_in = 1'b1;
        step_to(81);  check("burst_kvo81", key_valid_out, 1'b1);
        check("burst_key3", key_out, 4'd3);
        step_to(82);  key_valid_in = 1'b0;
        step_to(84);  key_in = 4'd9; key_valid_in = 1'b1;
        step_to(86);  key_valid_in = 1'b0;
        step_to(87);  check("burst_cnt87", fifo_count, 3'd2);
        step_to(88);  check("burst_kvo88", key_valid_out, 1'b1);
        step_to(89);  check("burst_kvo89", key_valid_out, 1'b0);
        check("burst_key3_hold", key_out, 4'd3);
        step_to(100); check("burst_kvo100", key_valid_out, 1'b0);
        step_to(101); check("burst_kvo101", key_valid_out, 1'b1);
        check("burst_key7", key_out, 4'd7);
        check("burst_cnt101", fifo_count, 3'd1);
        step_to(109); check("burst_kvo109", key_valid_out, 1'b0);
        step_to(120); check("burst_kvo120", key_valid_out, 1'b0);
        check("burst_key7_hold", key_out, 4'd7);
        step_to(121); check("burst_kvo121", key_valid_out, 1'b1);
        check("burst_key9", key_out, 4'd9);
        check("burst_cnt121", fifo_count, 3'd0);
        step_to(128); check("burst_kvo128", key_valid_out, 1'b1);
        step_to(129); check("burst_kvo129", key_valid_out, 1'b0);

        // Overflow: six presses (1,2,4,6,8,10) before the second pop
        step_to(140); key_in = 4'd1;  key_valid_in = 1'b1;
        step_to(141); key_valid_in = 1'b0;
        step_to(142); key_in = 4'd2;  key_valid_in = 1'b1;
        step_to(143); key_valid_in = 1'b0;
        step_to(144); key_in = 4'd4;  key_valid_in = 1'b1;
        step_to(145); key_valid_in = 1'b0;
        check("ovf_first_kvo", key_valid_out, 1'b1);
        check("ovf_first_key", key_out, 4'd1);
        check("ovf_cnt145", fifo_count, 3'd1);
        step_to(146); key_in = 4'd6;  key_valid_in = 1'b1;
        step_to(147); key_valid_in = 1'b0;
        step_to(148); key_in = 4'd8;  key_valid_in = 1'b1;
        step_to(149); key_valid_in = 1'b0;
        step_to(150); key_in = 4'd10; key_valid_in = 1'b1;
        step_to(151); key_valid_in = 1'b0;
        step_to(152); check("ovf_cnt_full", fifo_count, 3'd4);
        check("ovf_not_yet", overflow, 1'b0);
        step_to(153); check("ovf_cnt_drop", fifo_count, 3'd4);
        check("ovf_set", overflow, 1'b1);
        step_to(165); check("ovf_key2", key_out, 4'd2);
        check("ovf_kvo165", key_valid_out, 1'b1);
        check("ovf_cnt165", fifo_count, 3'd3);
        step_to(185); check("ovf_key4", key_out, 4'd4);
        check("ovf_kvo185", key_valid_out, 1'b1);
        step_to(205); check("ovf_key6", key_out, 4'd6);
        check("ovf_kvo205", key_valid_out, 1'b1);
        step_to(225); check("ovf_key8", key_out, 4'd8);
        check("ovf_kvo225", key_valid_out, 1'b1);
        check("ovf_cnt225", fifo_count, 3'd0);
        step_to(245); check("ovf_no_sixth", key_valid_out, 1'b0);
        check("ovf_key_last", key_out, 4'd8);
        step_to(246); check("ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        step_to(247); clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Push coinciding with an idle pop while full
        step_to(248); key_in = 4'd11; key_valid_in = 1'b1;
        step_to(249); key_valid_in = 1'b0;
        step_to(251); check("pp_cnt251", fifo_count, 3'd1);
        step_to(253); check("pp_key11", key_out, 4'd11);
        check("pp_kvo253", key_valid_out, 1'b1);
        step_to(254); key_in = 4'd12; key_valid_in = 1'b1;
        step_to(255); key_valid_in = 1'b0;
        step_to(256); key_in = 4'd13; key_valid_in = 1'b1;
        step_to(257); key_valid_in = 1'b0;
        step_to(258); key_in = 4'd14; key_valid_in = 1'b1;
        step_to(259); key_valid_in = 1'b0;
        step_to(260); key_in = 4'd15; key_valid_in = 1'b1;
        step_to(261); key_valid_in = 1'b0;
        step_to(263); check("pp_cnt_full", fifo_count, 3'd4);
        step_to(270); key_in = 4'd3;  key_valid_in = 1'b1;
        step_to(271); key_valid_in = 1'b0;
        step_to(272); check("pp_cnt272", fifo_count, 3'd4);
        check("pp_kvo272", key_valid_out, 1'b0);
        step_to(273); check("pp_cnt_same", fifo_count, 3'd4);
        check("pp_no_ovf", overflow, 1'b0);
        check("pp_kvo273", key_valid_out, 1'b1);
        check("pp_key12", key_out, 4'd12);

        // Mid-replay reset during ASSERT
        step_to(275); check("mr_kvo_before", key_valid_out, 1'b1);
        rst_n = 1'b0;
        step_to(276); check("mr_kvo", key_valid_out, 1'b0);
        check("mr_cnt", fifo_count, 3'd0);
        check("mr_key", key_out, 4'd0);
        check("mr_tick", tick, 1'b0);
        rst_n = 1'b1;
        for (int i = 277; i <= 336; i++) begin
            step_to(i);
            check("mr_no_stale_kvo", key_valid_out, 1'b0);
            check("mr_no_stale_cnt", fifo_count, 3'd0);
        end
        check("mr_key_after", key_out, 4'd0);
        check("mr_ovf_after", overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
